// File: rtl/test_ctrl_pkg.sv
// Shared definitions for the BRAM test control unit and the master that drives it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package test_ctrl_pkg;

    // Control-unit slave word addresses
    localparam logic [2:0] REG_GO       = 3'd0;
    localparam logic [2:0] REG_SET_ADDR = 3'd1;
    localparam logic [2:0] REG_NUM      = 3'd2;
    localparam logic [2:0] REG_LOCK     = 3'd3;
    localparam logic [2:0] REG_ID       = 3'd4;

    // err_code values reported by the master
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ID      = 3'd1;
    localparam logic [2:0] ERR_LOCK    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_COUNT   = 3'd4;

    // Largest end count the BRAM can take
    localparam logic [11:0] MAX_COUNT = 12'd2048;

    // Master sequencer states
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHK_CNT = 4'd1,
        S_RD_ID   = 4'd2,
        S_WT_ID   = 4'd3,
        S_RD_LOCK = 4'd4,
        S_WT_LOCK = 4'd5,
        S_WR_ADDR = 4'd6,
        S_WR_NUM  = 4'd7,
        S_WR_GO   = 4'd8,
        S_POLL_RD = 4'd9,
        S_POLL_WT = 4'd10,
        S_GAP     = 4'd11,
        S_ABORT   = 4'd12,
        S_FINISH  = 4'd13,
        S_FAIL    = 4'd14
    } state_t;

endpackage

// File: rtl/test_run_master.sv
// Avalon-MM master sequencing one BRAM test run: ID/lock check, program, go, poll, report.
// Latency: every bus strobe is preceded by one idle cycle; read data is consumed 1 cycle after read.
// Backpressure: none on the bus (slave has no waitrequest); start is ignored while busy.
module test_run_master
    import test_ctrl_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int MAX_POLLS  = 65535,
    parameter int CHECK_ID   = 1,
    parameter int CHECK_LOCK = 1
) (
    input  logic        avalon_clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [10:0] start_addr,
    input  logic [11:0] count,
    input  logic [31:0] expected_id,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [15:0] poll_count,
    output logic [2:0]  address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [15:0] MAX_P    = 16'(MAX_POLLS);
    localparam logic [15:0] GAP_LAST = 16'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    state_t      state_q, state_d;
    // ph_q splits each strobe state: 0 = idle cycle while the strobe is set up, 1 = strobe on the bus
    logic        ph_q, ph_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [15:0] poll_count_q, poll_count_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]  address_q, address_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic [31:0] writedata_q, writedata_d;
    logic [10:0] saddr_q, saddr_d;
    logic [11:0] cnt_q, cnt_d;

    // Next-state and next-output logic; strobes default low so each lasts exactly one cycle
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        err_code_d   = err_code_q;
        poll_count_d = poll_count_q;
        gap_cnt_d    = gap_cnt_q;
        address_d    = address_q;
        write_d      = 1'b0;
        read_d       = 1'b0;
        writedata_d  = writedata_q;
        saddr_d      = saddr_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_CHK_CNT;
                    busy_d       = 1'b1;
                    err_code_d   = ERR_NONE;
                    poll_count_d = '0;
                    saddr_d      = start_addr;
                    cnt_d        = count;
                    ph_d         = 1'b0;
                end
            end
            S_CHK_CNT: begin
                if (cnt_q > MAX_COUNT) begin
                    err_code_d = ERR_COUNT;
                    state_d    = S_FAIL;
                end else begin
                    state_d = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (!ph_q) begin
                    ph_d = 1'b1; read_d = 1'b1; address_d = REG_ID;
                end else begin
                    ph_d = 1'b0; state_d = S_WT_ID;
                end
            end
            S_WT_ID: begin
                if ((CHECK_ID != 0) && (readdata != expected_id)) begin
                    err_code_d = ERR_ID;
                    state_d    = S_FAIL;
                end else begin
                    state_d = S_RD_LOCK;
                end
            end
            S_RD_LOCK: begin
                if (!ph_q) begin
                    ph_d = 1'b1; read_d = 1'b1; address_d = REG_LOCK;
                end else begin
                    ph_d = 1'b0; state_d = S_WT_LOCK;
                end
            end
            S_WT_LOCK: begin
                if ((CHECK_LOCK != 0) && !readdata[0]) begin
                    err_code_d = ERR_LOCK;
                    state_d    = S_FAIL;
                end else begin
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (!ph_q) begin
                    ph_d = 1'b1; write_d = 1'b1; address_d = REG_SET_ADDR;
                    writedata_d = {21'b0, saddr_q};
                end else begin
                    ph_d = 1'b0; state_d = S_WR_NUM;
                end
            end
            S_WR_NUM: begin
                if (!ph_q) begin
                    ph_d = 1'b1; write_d = 1'b1; address_d = REG_NUM;
                    writedata_d = {20'b0, cnt_q};
                end else begin
                    ph_d = 1'b0; state_d = S_WR_GO;
                end
            end
            S_WR_GO: begin
                if (!ph_q) begin
                    ph_d = 1'b1; write_d = 1'b1; address_d = REG_GO;
                    writedata_d = 32'h1;
                end else begin
                    ph_d = 1'b0; state_d = S_POLL_RD;
                end
            end
            S_POLL_RD: begin
                if (!ph_q) begin
                    ph_d = 1'b1; read_d = 1'b1; address_d = REG_GO;
                    if (poll_count_q < MAX_P) poll_count_d = poll_count_q + 16'd1;
                end else begin
                    ph_d = 1'b0; state_d = S_POLL_WT;
                end
            end
            S_POLL_WT: begin
                if (!readdata[0]) begin
                    state_d = S_FINISH;
                end else if (poll_count_q == MAX_P) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ABORT;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_POLL_RD;
                else gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_ABORT: begin
                // Slave still holds go=1 after a timeout; clear it before reporting
                if (!ph_q) begin
                    ph_d = 1'b1; write_d = 1'b1; address_d = REG_GO;
                    writedata_d = 32'h0;
                end else begin
                    ph_d = 1'b0; state_d = S_FAIL;
                end
            end
            S_FINISH: begin
                done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end
            S_FAIL: begin
                error_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE; busy_d = 1'b0; ph_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ph_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            poll_count_q <= '0;
            gap_cnt_q    <= '0;
            address_q    <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            writedata_q  <= '0;
            saddr_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            poll_count_q <= poll_count_d;
            gap_cnt_q    <= gap_cnt_d;
            address_q    <= address_d;
            write_q      <= write_d;
            read_q       <= read_d;
            writedata_q  <= writedata_d;
            saddr_q      <= saddr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign poll_count = poll_count_q;
    assign address    = address_q;
    assign write      = write_q;
    assign read       = read_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_test_run_master.sv
// Directed bench: three masters (default, lock check off, 8-poll timeout) each on a slave model.
module tb_test_run_master;
    import test_ctrl_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [2:0]  start_v, busy_v, done_v, error_v, rd_v, wr_v, lock_v, never_v;
    logic [10:0] start_addr;
    logic [11:0] count;
    logic [31:0] expected_id, slave_id;
    logic        log_clr;
    int          go_delay;
    int          n_chk = 0;
    int          n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0]  errc, addr;
        logic [15:0] pc;
        logic [31:0] wdat, rdata;
        logic        go, prev_stb;
        int          clr_cnt, wcnt, rcnt, rd0_cnt, done_cnt, err_cnt, bad_cnt;
        logic [2:0]  wa [16];
        logic [31:0] wd [16];

        test_run_master #(
            .POLL_GAP  (4),
            .MAX_POLLS ((g == 2) ? 8 : 65535),
            .CHECK_ID  (1),
            .CHECK_LOCK((g == 1) ? 0 : 1)
        ) u_dut (
            .avalon_clock(clk),
            .resetn      (resetn),
            .start       (start_v[g]),
            .start_addr  (start_addr),
            .count       (count),
            .expected_id (expected_id),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .error       (error_v[g]),
            .err_code    (errc),
            .poll_count  (pc),
            .address     (addr),
            .write       (wr_v[g]),
            .read        (rd_v[g]),
            .writedata   (wdat),
            .readdata    (rdata)
        );

        // Control-unit slave model plus bus activity log
        always @(posedge clk) begin
            if (!resetn) begin
                go    <= 1'b0;
                rdata <= 32'hA5A5_A5A4;
            end else begin
                if (rd_v[g]) begin
                    case (addr)
                        REG_GO:       rdata <= {31'b0, go};
                        REG_LOCK:     rdata <= {31'b0, lock_v[g]};
                        REG_ID:       rdata <= slave_id;
                        default:      rdata <= 32'h0;
                    endcase
                end else begin
                    rdata <= 32'hA5A5_A5A4;
                end
                if (wr_v[g] && addr == REG_GO) begin
                    go      <= wdat[0];
                    clr_cnt <= go_delay;
                end else if (go && !never_v[g]) begin
                    if (clr_cnt <= 1) go <= 1'b0;
                    else clr_cnt <= clr_cnt - 1;
                end
            end
            if (log_clr) begin
                wcnt <= 0; rcnt <= 0; rd0_cnt <= 0; done_cnt <= 0; err_cnt <= 0; bad_cnt <= 0;
                prev_stb <= 1'b0;
            end else begin
                if (wr_v[g]) begin
                    if (wcnt < 16) begin
                        wa[wcnt[3:0]] <= addr;
                        wd[wcnt[3:0]] <= wdat;
                    end
                    wcnt <= wcnt + 1;
                end
                if (rd_v[g]) rcnt <= rcnt + 1;
                if (rd_v[g] && addr == REG_GO) rd0_cnt <= rd0_cnt + 1;
                if (done_v[g]) done_cnt <= done_cnt + 1;
                if (error_v[g]) err_cnt <= err_cnt + 1;
                if ((rd_v[g] && wr_v[g]) || ((rd_v[g] || wr_v[g]) && prev_stb) || (done_v[g] && error_v[g]))
                    bad_cnt <= bad_cnt + 1;
                prev_stb <= rd_v[g] | wr_v[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_logs();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic pulse_start(input int g, input logic [10:0] a, input logic [11:0] c);
        start_addr = a;
        count      = c;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v    = '0;
    endtask

    task automatic wait_end(input int g, input string tag);
        int n = 0;
        while (!(done_v[g] | error_v[g]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ended"}, 32'(n < 2000), 32'd1);
        tick(2);
    endtask

    initial begin
        resetn = 1'b0; start_v = '0; log_clr = 1'b0;
        lock_v = 3'b111; never_v = 3'b100; go_delay = 40;
        expected_id = 32'd1; slave_id = 32'd1; start_addr = '0; count = '0;
        tick(3);
        // Reset state
        chk("rst_busy", 32'(busy_v[0]), 0);
        chk("rst_done_err", 32'({done_v[0], error_v[0]}), 0);
        chk("rst_rd_wr", 32'({rd_v[0], wr_v[0]}), 0);
        chk("rst_addr", 32'(g_dut[0].addr), 0);
        chk("rst_wdat", g_dut[0].wdat, 0);
        chk("rst_errc", 32'(g_dut[0].errc), 0);
        chk("rst_pc", 32'(g_dut[0].pc), 0);
        resetn = 1'b1;
        tick(1);
        clr_logs();

        // 1: normal run, with a second start while busy that must be ignored
        pulse_start(0, 11'd0, 12'd16);
        chk("t1_busy", 32'(busy_v[0]), 1);
        tick(2);
        pulse_start(0, 11'd9, 12'd9);
        wait_end(0, "t1");
        chk("t1_done", g_dut[0].done_cnt, 1);
        chk("t1_err", g_dut[0].err_cnt, 0);
        chk("t1_wcnt", g_dut[0].wcnt, 3);
        chk("t1_wa0", 32'(g_dut[0].wa[0]), 1);
        chk("t1_wd0", g_dut[0].wd[0], 0);
        chk("t1_wa1", 32'(g_dut[0].wa[1]), 2);
        chk("t1_wd1", g_dut[0].wd[1], 16);
        chk("t1_wa2", 32'(g_dut[0].wa[2]), 0);
        chk("t1_wd2", g_dut[0].wd[2], 1);
        chk("t1_errc", 32'(g_dut[0].errc), 0);
        chk("t1_pc", 32'(g_dut[0].pc), g_dut[0].rd0_cnt);
        chk("t1_multi_poll", 32'(g_dut[0].rd0_cnt >= 2), 1);
        chk("t1_reads", g_dut[0].rcnt, g_dut[0].rd0_cnt + 2);
        chk("t1_bus_rules", g_dut[0].bad_cnt, 0);
        chk("t1_idle", 32'(busy_v[0]), 0);

        // 2: ID mismatch
        clr_logs();
        expected_id = 32'd2;
        pulse_start(0, 11'd0, 12'd16);
        wait_end(0, "t2");
        chk("t2_err", g_dut[0].err_cnt, 1);
        chk("t2_done", g_dut[0].done_cnt, 0);
        chk("t2_errc", 32'(g_dut[0].errc), 1);
        chk("t2_wcnt", g_dut[0].wcnt, 0);
        chk("t2_reads", g_dut[0].rcnt, 1);
        expected_id = 32'd1;

        // 3: PLL not locked, then same with the lock check disabled
        clr_logs();
        lock_v[0] = 1'b0; lock_v[1] = 1'b0;
        pulse_start(0, 11'd0, 12'd16);
        wait_end(0, "t3a");
        chk("t3a_err", g_dut[0].err_cnt, 1);
        chk("t3a_errc", 32'(g_dut[0].errc), 2);
        chk("t3a_wcnt", g_dut[0].wcnt, 0);
        chk("t3a_reads", g_dut[0].rcnt, 2);
        pulse_start(1, 11'd3, 12'd10);
        wait_end(1, "t3b");
        chk("t3b_done", g_dut[1].done_cnt, 1);
        chk("t3b_err", g_dut[1].err_cnt, 0);
        chk("t3b_wcnt", g_dut[1].wcnt, 3);
        chk("t3b_wd0", g_dut[1].wd[0], 3);
        chk("t3b_wd1", g_dut[1].wd[1], 10);
        chk("t3b_errc", 32'(g_dut[1].errc), 0);
        lock_v = 3'b111;

        // 4: go never clears, 8-poll limit
        clr_logs();
        pulse_start(2, 11'd0, 12'd16);
        wait_end(2, "t4");
        chk("t4_polls", g_dut[2].rd0_cnt, 8);
        chk("t4_pc", 32'(g_dut[2].pc), 8);
        chk("t4_wcnt", g_dut[2].wcnt, 4);
        chk("t4_abort_a", 32'(g_dut[2].wa[3]), 0);
        chk("t4_abort_d", g_dut[2].wd[3], 0);
        chk("t4_err", g_dut[2].err_cnt, 1);
        chk("t4_errc", 32'(g_dut[2].errc), 3);
        chk("t4_bus_rules", g_dut[2].bad_cnt, 0);

        // 5: count over the BRAM size, then exactly at the limit
        clr_logs();
        pulse_start(0, 11'd0, 12'd3000);
        wait_end(0, "t5a");
        chk("t5a_err", g_dut[0].err_cnt, 1);
        chk("t5a_errc", 32'(g_dut[0].errc), 4);
        chk("t5a_bus", g_dut[0].rcnt + g_dut[0].wcnt, 0);
        clr_logs();
        pulse_start(0, 11'd0, 12'd2048);
        wait_end(0, "t5b");
        chk("t5b_done", g_dut[0].done_cnt, 1);
        chk("t5b_wd1", g_dut[0].wd[1], 2048);
        chk("t5b_errc", 32'(g_dut[0].errc), 0);

        // 6: reset while waiting between polls, then a fresh run
        clr_logs();
        pulse_start(0, 11'd0, 12'd16);
        begin
            int n = 0;
            while (g_dut[0].rd0_cnt < 1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("t6_first_poll", 32'(n < 200), 1);
        end
        tick(2);
        resetn = 1'b0;
        tick(1);
        chk("t6_busy", 32'(busy_v[0]), 0);
        chk("t6_rd_wr", 32'({rd_v[0], wr_v[0]}), 0);
        chk("t6_pc", 32'(g_dut[0].pc), 0);
        resetn = 1'b1;
        tick(1);
        clr_logs();
        pulse_start(0, 11'd5, 12'd5);
        wait_end(0, "t6");
        chk("t6_done", g_dut[0].done_cnt, 1);
        chk("t6_wcnt", g_dut[0].wcnt, 3);
        chk("t6_wa0", 32'(g_dut[0].wa[0]), 1);
        chk("t6_wd0", g_dut[0].wd[0], 5);
        chk("t6_wa1", 32'(g_dut[0].wa[1]), 2);
        chk("t6_wd1", g_dut[0].wd[1], 5);
        chk("t6_wa2", 32'(g_dut[0].wa[2]), 0);
        chk("t6_wd2", g_dut[0].wd[2], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
